// File: rtl/pipe_ctrl_pkg.sv
// Arya front-end sequencing: shared state encodings and flush-count helpers.
// Used by pipe_hazard_ctrl (stats enabled with STALL_STATS_EN).
package pipe_ctrl_pkg;

  localparam int REM_W = 4;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_FLUSH  = 2'd1;
  localparam logic [1:0] ST_FREEZE = 2'd2;

  localparam int FLUSH_MIN = 1;
  localparam int FLUSH_MAX = 15;

  // Remaining-count value loaded on a taken branch; out-of-range
  // configurations are clamped to the legal window.
  function automatic logic [REM_W-1:0] flush_rem_init(input int fc);
    int c;
    c = fc;
    if (c < FLUSH_MIN) c = FLUSH_MIN;
    if (c > FLUSH_MAX) c = FLUSH_MAX;
    return REM_W'(c - 1);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags a decode operand that depends on a load
// still in execute. Purely combinational.
module hazard_detect #(
  parameter int AW = 5
) (
  input  logic [AW-1:0] id_rs_addr,
  input  logic [AW-1:0] id_rt_addr,
  input  logic          id_rs_used,
  input  logic          id_rt_used,
  input  logic          ex_load,
  input  logic [AW-1:0] ex_rd_addr,
  output logic          hazard
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_rs_used && (id_rs_addr == ex_rd_addr);
  assign rt_hit = id_rt_used && (id_rt_addr == ex_rd_addr);
  assign hazard = ex_load && (ex_rd_addr != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Arya pipeline sequencer: PC / IF-ID / ID-EX enables and flushes.
// Statistics counters are built only when STALL_STATS_EN is defined.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int FLUSH_CYCLES       = 2,
  parameter int CNT_WIDTH          = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [REGFILE_ADDR_WIDTH-1:0] id_rs_addr,
  input  logic [REGFILE_ADDR_WIDTH-1:0] id_rt_addr,
  input  logic                          id_rs_used,
  input  logic                          id_rt_used,
  input  logic                          ex_load,
  input  logic [REGFILE_ADDR_WIDTH-1:0] ex_rd_addr,
  input  logic                          br_taken,
  input  logic                          mem_busy,
  output logic                          pc_en,
  output logic                          fd_en,
  output logic                          de_en,
  output logic                          fd_flush,
  output logic                          de_flush,
  output logic [1:0]                    state,
  output logic [CNT_WIDTH-1:0]          stall_cnt,
  output logic [CNT_WIDTH-1:0]          flush_cnt,
  output logic [CNT_WIDTH-1:0]          freeze_cnt
);

  localparam logic [REM_W-1:0] REM_INIT = flush_rem_init(FLUSH_CYCLES);

  logic [1:0]       state_q, state_d;
  logic [1:0]       ret_q, ret_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [1:0]       eff;
  logic             hazard;
  logic             hz_ev, fl_ev, fz_ev;

  hazard_detect #(
    .AW(REGFILE_ADDR_WIDTH)
  ) u_hazard (
    .id_rs_addr(id_rs_addr),
    .id_rt_addr(id_rt_addr),
    .id_rs_used(id_rs_used),
    .id_rt_used(id_rt_used),
    .ex_load   (ex_load),
    .ex_rd_addr(ex_rd_addr),
    .hazard    (hazard)
  );

  // Effective state: a released freeze behaves as the saved state;
  // any illegal encoding behaves as RUN.
  always_comb begin
    eff = state_q;
    if (state_q == ST_FREEZE) eff = ret_q;
    if (eff != ST_FLUSH) eff = ST_RUN;
  end

  // Prioritised strobe generation and next-state selection.
  always_comb begin
    pc_en    = 1'b0;
    fd_en    = 1'b0;
    de_en    = 1'b0;
    fd_flush = 1'b0;
    de_flush = 1'b0;
    state_d  = ST_RUN;
    ret_d    = ret_q;
    rem_d    = rem_q;
    hz_ev    = 1'b0;
    fl_ev    = 1'b0;
    fz_ev    = 1'b0;
    if (reset) begin
      fd_flush = 1'b1;
      de_flush = 1'b1;
      ret_d    = ST_RUN;
      rem_d    = '0;
    end else if (mem_busy) begin
      state_d = ST_FREEZE;
      ret_d   = eff;
      fz_ev   = 1'b1;
    end else if (br_taken) begin
      pc_en    = 1'b1;
      fd_en    = 1'b1;
      de_en    = 1'b1;
      fd_flush = 1'b1;
      de_flush = 1'b1;
      rem_d    = REM_INIT;
      state_d  = (REM_INIT != '0) ? ST_FLUSH : ST_RUN;
      fl_ev    = 1'b1;
    end else if (eff == ST_FLUSH) begin
      pc_en    = 1'b1;
      fd_en    = 1'b1;
      de_en    = 1'b1;
      fd_flush = 1'b1;
      rem_d    = (rem_q == '0) ? '0 : rem_q - REM_W'(1);
      state_d  = (rem_q > REM_W'(1)) ? ST_FLUSH : ST_RUN;
      fl_ev    = 1'b1;
    end else if (hazard) begin
      de_en    = 1'b1;
      de_flush = 1'b1;
      hz_ev    = 1'b1;
    end else begin
      pc_en = 1'b1;
      fd_en = 1'b1;
      de_en = 1'b1;
    end
  end

  // Registered FSM state, saved return state and flush remainder.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      ret_q   <= ST_RUN;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      rem_q   <= rem_d;
    end
  end

  assign state = state_q;

`ifdef STALL_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] stall_q, flush_q, frz_q;

  // Saturating event counters, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
      frz_q   <= '0;
    end else begin
      if (hz_ev && !(&stall_q)) stall_q <= stall_q + CNT_ONE;
      if (fl_ev && !(&flush_q)) flush_q <= flush_q + CNT_ONE;
      if (fz_ev && !(&frz_q))   frz_q   <= frz_q + CNT_ONE;
    end
  end

  assign stall_cnt  = stall_q;
  assign flush_cnt  = flush_q;
  assign freeze_cnt = frz_q;
`else
  logic unused_ev;

  assign unused_ev  = hz_ev ^ fl_ev ^ fz_ev;
  assign stall_cnt  = '0;
  assign flush_cnt  = '0;
  assign freeze_cnt = '0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the Arya core front end. Generates the enable and flush strobes for the PC register, the fetch/decode pipe register and the decode/execute pipe register. Resolves load-use stalls, taken-branch squashes and data-memory freezes with a fixed priority. One instance per core sits beside the pipe registers in the core top level.

## Interface
Parameters:
- REGFILE_ADDR_WIDTH, 5: register-file address width.
- FLUSH_CYCLES, 2: wrong-path bubbles inserted per taken branch; legal range 1..15.
- CNT_WIDTH, 32: width of the statistics counters.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- id_rs_addr  in  REGFILE_ADDR_WIDTH  rs of the instruction in decode.
- id_rt_addr  in  REGFILE_ADDR_WIDTH  rt of the instruction in decode.
- id_rs_used, id_rt_used  in  1  decode instruction actually reads rs / rt.
- ex_load  in  1  instruction in execute is a load.
- ex_rd_addr  in  REGFILE_ADDR_WIDTH  destination of the execute instruction.
- br_taken  in  1  branch in execute resolved taken; level, valid only when not frozen.
- mem_busy  in  1  data memory not ready; the whole pipe must hold.
- pc_en  out  1  PC register load enable.
- fd_en, de_en  out  1  pipe register enables.
- fd_flush, de_flush  out  1  pipe register clears; the parent ORs each with reset into the register's reset input, so flush overrides enable.
- state  out  2  current FSM state, debug only.
- stall_cnt, flush_cnt, freeze_cnt  out  CNT_WIDTH  statistics counters (see Configuration).

## Operation
- States: RUN=0, FLUSH=1, FREEZE=2; 3 is illegal and recovers to RUN on the next edge.
- Priority within a cycle: reset > mem_busy > br_taken > load-use.
- Load-use hazard: ex_load && ex_rd_addr!=0 && ((id_rs_used && id_rs_addr==ex_rd_addr) || (id_rt_used && id_rt_addr==ex_rd_addr)).
- RUN, no event: pc_en=fd_en=de_en=1, flushes=0.
- RUN, hazard: pc_en=0, fd_en=0, de_en=1, de_flush=1 (one bubble); state stays RUN.
- RUN or FLUSH, br_taken: pc_en=1, fd_flush=1, de_flush=1.
  - Load remaining count rem = FLUSH_CYCLES-1.
  - Next state is FLUSH if rem>0, else RUN.
- FLUSH: pc_en=1, fd_flush=1, de_en=1, de_flush=0; rem decrements each cycle; exit to RUN when rem reaches 0.
  - Load-use detection is masked (decode holds a bubble).
  - br_taken restarts the count.
- mem_busy in any state: all enables 0, all flushes 0; enter FREEZE and save the return state (RUN/FLUSH) and rem unchanged.
- FREEZE: outputs as above while mem_busy=1. On the first cycle with mem_busy=0, return to the saved state; outputs that cycle are those of the saved state (rem resumes, not restarted).
- Reset: state=RUN, rem=0, saved state=RUN. While reset=1: pc_en=fd_en=de_en=0, fd_flush=de_flush=1, counters cleared. Reset mid-FLUSH or mid-FREEZE discards all pending work.

## Timing
- Mealy outputs: stall, flush and freeze strobes respond combinationally in the same cycle as the causing input (0-cycle latency).
- state and rem are registered.
- Load-use stall costs exactly 1 cycle; a taken branch costs FLUSH_CYCLES cycles plus any freeze cycles.
- br_taken and a hazard in the same cycle: branch wins, no stall is recorded.
- mem_busy and br_taken in the same cycle: freeze wins. br_taken is re-presented by the held execute stage after the freeze.

## Configuration
- STALL_STATS_EN defined: stall_cnt counts hazard cycles, flush_cnt counts FLUSH-state cycles plus branch cycles, freeze_cnt counts cycles with mem_busy=1 outside reset. Each counter saturates at all-ones and clears on reset.
- Undefined: counters are not built; the three ports are tied to 0. The port list is unchanged.

## Structure
- Package pipe_ctrl_pkg: state encodings (RUN/FLUSH/FREEZE), the FLUSH_CYCLES legal range, and the rem width (4 bits).
- Sub-module hazard_detect: purely combinational load-use comparator; inputs are the id_*/ex_* signals, output is hazard.
- The FSM, rem counter and statistics counters live in pipe_hazard_ctrl.

## Test plan
- Reset held 3 cycles -> enables 0, flushes 1, state=0; first cycle after release has pc_en=fd_en=de_en=1.
- ex_load=1, ex_rd_addr=5, id_rs_addr=5, id_rs_used=1 for 1 cycle -> pc_en=0, fd_en=0, de_flush=1 that cycle only; stall_cnt=1. Repeat with ex_rd_addr=0 -> no stall.
- br_taken pulse with FLUSH_CYCLES=2 -> cycle0 fd_flush=de_flush=1, cycle1 state=1 with fd_flush=1, cycle2 state=0; flush_cnt=2. FLUSH_CYCLES=1 -> no FLUSH state entered.
- br_taken, then mem_busy=1 for 4 cycles during FLUSH -> enables 0, state=2 for 4 cycles, then FLUSH resumes for the remaining 1 cycle; freeze_cnt=4.
- br_taken and hazard together -> branch response, stall_cnt unchanged. mem_busy and br_taken together -> freeze response.
- Reset asserted mid-FLUSH -> next cycle state=0, rem=0, counters 0. Build without STALL_STATS_EN -> counter ports read 0 throughout.
